// File: rtl/cpu_if_regs.sv
// ---------------------------------------------------------------------------
// cpu_if_regs
//   AXI4-Lite slave register bank terminating the PS-to-PL cpu_if master
//   port. Provides a version ID, a scratch register, LED control with a
//   hardware blinker, a free-running uptime counter and a sticky W1C status
//   register. Everything runs on the 200 MHz fabric clock.
//
//   Register map (byte offset, only address bits [7:2] decoded):
//     0x00 VERSION   RO   returns the VERSION parameter
//     0x04 SCRATCH   RW   32-bit, per-byte strobes
//     0x08 LED_CTRL  RW   [2:0] led_sw, [8] blink_en
//     0x0C BLINK_DIV RW   blink half-period in cycles, per-byte strobes
//     0x10 UPTIME    RO   +1 per cycle, wraps
//     0x14 STATUS    W1C  [0] lock_lost, [1] bus_err
//   Offsets above 0x14 answer SLVERR; reads return 0, writes do nothing.
//
// Ports:
//   clk_200, rst_200      fabric clock, asynchronous active-high reset
//   cpu_if_aw* / w* / b*  AXI4-Lite write address, data and response
//   cpu_if_ar* / r*       AXI4-Lite read address and data
//   mmcm_locked           asynchronous lock flag, synchronised internally
//   led_out               registered board LED drive
// ---------------------------------------------------------------------------
module cpu_if_regs #(
    parameter int unsigned ADDR_W        = 32,
    parameter logic [31:0] VERSION       = 32'h0001_0000,
    parameter logic [31:0] BLINK_DIV_RST = 32'd100_000_000
) (
    input  logic              clk_200,
    input  logic              rst_200,

    input  logic [ADDR_W-1:0] cpu_if_awaddr,
    input  logic [2:0]        cpu_if_awprot,
    input  logic              cpu_if_awvalid,
    output logic              cpu_if_awready,
    input  logic [31:0]       cpu_if_wdata,
    input  logic [3:0]        cpu_if_wstrb,
    input  logic              cpu_if_wvalid,
    output logic              cpu_if_wready,
    output logic [1:0]        cpu_if_bresp,
    output logic              cpu_if_bvalid,
    input  logic              cpu_if_bready,

    input  logic [ADDR_W-1:0] cpu_if_araddr,
    input  logic [2:0]        cpu_if_arprot,
    input  logic              cpu_if_arvalid,
    output logic              cpu_if_arready,
    output logic [31:0]       cpu_if_rdata,
    output logic [1:0]        cpu_if_rresp,
    output logic              cpu_if_rvalid,
    input  logic              cpu_if_rready,

    input  logic              mmcm_locked,
    output logic [2:0]        led_out
);

    typedef enum logic [5:0] {
        REG_VERSION   = 6'd0,
        REG_SCRATCH   = 6'd1,
        REG_LED_CTRL  = 6'd2,
        REG_BLINK_DIV = 6'd3,
        REG_UPTIME    = 6'd4,
        REG_STATUS    = 6'd5
    } reg_idx_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Protection bits and undecoded address bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{cpu_if_awprot, cpu_if_arprot, cpu_if_awaddr, cpu_if_araddr};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Init flop: keeps every ready low until the first edge after reset.
    // -----------------------------------------------------------------------
    logic init;

    always_ff @(posedge clk_200 or posedge rst_200) begin
        if (rst_200) init <= 1'b0;
        else         init <= 1'b1;
    end

    // -----------------------------------------------------------------------
    // Write channel
    // -----------------------------------------------------------------------
    logic        aw_held, w_held;
    logic [5:0]  aw_idx_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        bvalid;
    logic [1:0]  bresp_q;

    logic        aw_hs, w_hs, wr_fire, wr_mapped;
    logic [5:0]  wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    assign cpu_if_awready = init & ~aw_held & ~bvalid;
    assign cpu_if_wready  = init & ~w_held  & ~bvalid;
    assign cpu_if_bvalid  = bvalid;
    assign cpu_if_bresp   = bresp_q;

    assign aw_hs = cpu_if_awvalid & cpu_if_awready;
    assign w_hs  = cpu_if_wvalid  & cpu_if_wready;

    // The write commits on the edge where the second half arrives; whichever
    // half was captured earlier is taken from its holding register.
    assign wr_fire   = (aw_held | aw_hs) & (w_held | w_hs);
    assign wr_idx    = aw_held ? aw_idx_q : cpu_if_awaddr[7:2];
    assign wr_data   = w_held  ? w_data_q : cpu_if_wdata;
    assign wr_strb   = w_held  ? w_strb_q : cpu_if_wstrb;
    assign wr_mapped = (wr_idx <= REG_STATUS);

    always_ff @(posedge clk_200 or posedge rst_200) begin
        if (rst_200) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bvalid   <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            if (aw_hs) aw_idx_q <= cpu_if_awaddr[7:2];
            if (w_hs) begin
                w_data_q <= cpu_if_wdata;
                w_strb_q <= cpu_if_wstrb;
            end

            if (wr_fire) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_hs) aw_held <= 1'b1;
                if (w_hs)  w_held  <= 1'b1;
            end

            if (wr_fire) begin
                bvalid  <= 1'b1;
                bresp_q <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end else if (cpu_if_bready) begin
                bvalid  <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Register file
    // -----------------------------------------------------------------------
    logic [31:0] scratch;
    logic [2:0]  led_sw;
    logic        blink_en;
    logic [31:0] blink_div;
    logic [31:0] uptime;
    logic [1:0]  status;

    logic        we_scratch, we_led, we_div, we_status;

    assign we_scratch = wr_fire & (wr_idx == REG_SCRATCH);
    assign we_led     = wr_fire & (wr_idx == REG_LED_CTRL);
    assign we_div     = wr_fire & (wr_idx == REG_BLINK_DIV);
    assign we_status  = wr_fire & (wr_idx == REG_STATUS);

    always_ff @(posedge clk_200 or posedge rst_200) begin
        if (rst_200) begin
            scratch   <= '0;
            led_sw    <= '0;
            blink_en  <= 1'b0;
            blink_div <= BLINK_DIV_RST;
            uptime    <= '0;
        end else begin
            uptime <= uptime + 32'd1;
            if (we_scratch) scratch   <= merge_bytes(scratch, wr_data, wr_strb);
            if (we_div)     blink_div <= merge_bytes(blink_div, wr_data, wr_strb);
            if (we_led) begin
                if (wr_strb[0]) led_sw   <= wr_data[2:0];
                if (wr_strb[1]) blink_en <= wr_data[8];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Lock-loss detection: two-flop synchroniser plus a history flop for the
    // falling edge. Reset state is 0 so the post-reset rise never looks like
    // a loss.
    // -----------------------------------------------------------------------
    logic lock_meta, lock_sync, lock_prev, lock_fall;

    always_ff @(posedge clk_200 or posedge rst_200) begin
        if (rst_200) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
            lock_prev <= 1'b0;
        end else begin
            lock_meta <= mmcm_locked;
            lock_sync <= lock_meta;
            lock_prev <= lock_sync;
        end
    end

    assign lock_fall = lock_prev & ~lock_sync;

    // -----------------------------------------------------------------------
    // Read channel
    // -----------------------------------------------------------------------
    logic        rvalid;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        ar_hs;
    logic [5:0]  rd_idx;
    logic [31:0] rd_data;
    logic        rd_err;

    assign cpu_if_arready = init & ~rvalid;
    assign cpu_if_rvalid  = rvalid;
    assign cpu_if_rdata   = rdata_q;
    assign cpu_if_rresp   = rresp_q;

    assign ar_hs  = cpu_if_arvalid & cpu_if_arready;
    assign rd_idx = cpu_if_araddr[7:2];

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (rd_idx)
            REG_VERSION:   rd_data = VERSION;
            REG_SCRATCH:   rd_data = scratch;
            REG_LED_CTRL:  rd_data = {23'b0, blink_en, 5'b0, led_sw};
            REG_BLINK_DIV: rd_data = blink_div;
            REG_UPTIME:    rd_data = uptime;
            REG_STATUS:    rd_data = {30'b0, status};
            default:       rd_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk_200 or posedge rst_200) begin
        if (rst_200) begin
            rvalid  <= 1'b0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid  <= 1'b1;
            rdata_q <= rd_data;
            rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (cpu_if_rready) begin
            rvalid  <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // STATUS: sticky, write-one-to-clear, a set in the same cycle wins.
    // -----------------------------------------------------------------------
    logic [1:0] status_set, status_clr;

    assign status_set = {(wr_fire & ~wr_mapped) | (ar_hs & rd_err), lock_fall};
    assign status_clr = (we_status & wr_strb[0]) ? wr_data[1:0] : 2'b00;

    always_ff @(posedge clk_200 or posedge rst_200) begin
        if (rst_200) status <= '0;
        else         status <= (status & ~status_clr) | status_set;
    end

    // -----------------------------------------------------------------------
    // Blinker. The >= compare lets a BLINK_DIV write below the running count
    // take effect on the very next cycle; a divider of 0 behaves like 1.
    // -----------------------------------------------------------------------
    logic [31:0] blink_cnt;
    logic        blink_phase;
    logic [31:0] blink_lim;

    assign blink_lim = (blink_div == 32'd0) ? 32'd0 : blink_div - 32'd1;

    always_ff @(posedge clk_200 or posedge rst_200) begin
        if (rst_200) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!blink_en) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt >= blink_lim) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk_200 or posedge rst_200) begin
        if (rst_200)       led_out <= '0;
        else if (blink_en) led_out <= led_sw & {3{blink_phase}};
        else               led_out <= led_sw;
    end

endmodule

// File: tb/tb_cpu_if_regs.sv
module tb_cpu_if_regs;

    logic        clk_200 = 1'b0;
    logic        rst_200;
    logic [31:0] cpu_if_awaddr;
    logic [2:0]  cpu_if_awprot;
    logic        cpu_if_awvalid;
    logic        cpu_if_awready;
    logic [31:0] cpu_if_wdata;
    logic [3:0]  cpu_if_wstrb;
    logic        cpu_if_wvalid;
    logic        cpu_if_wready;
    logic [1:0]  cpu_if_bresp;
    logic        cpu_if_bvalid;
    logic        cpu_if_bready;
    logic [31:0] cpu_if_araddr;
    logic [2:0]  cpu_if_arprot;
    logic        cpu_if_arvalid;
    logic        cpu_if_arready;
    logic [31:0] cpu_if_rdata;
    logic [1:0]  cpu_if_rresp;
    logic        cpu_if_rvalid;
    logic        cpu_if_rready;
    logic        mmcm_locked;
    logic [2:0]  led_out;

    cpu_if_regs #(
        .ADDR_W        (32),
        .VERSION       (32'h0001_0000),
        .BLINK_DIV_RST (32'd100_000_000)
    ) dut (
        .clk_200        (clk_200),
        .rst_200        (rst_200),
        .cpu_if_awaddr  (cpu_if_awaddr),
        .cpu_if_awprot  (cpu_if_awprot),
        .cpu_if_awvalid (cpu_if_awvalid),
        .cpu_if_awready (cpu_if_awready),
        .cpu_if_wdata   (cpu_if_wdata),
        .cpu_if_wstrb   (cpu_if_wstrb),
        .cpu_if_wvalid  (cpu_if_wvalid),
        .cpu_if_wready  (cpu_if_wready),
        .cpu_if_bresp   (cpu_if_bresp),
        .cpu_if_bvalid  (cpu_if_bvalid),
        .cpu_if_bready  (cpu_if_bready),
        .cpu_if_araddr  (cpu_if_araddr),
        .cpu_if_arprot  (cpu_if_arprot),
        .cpu_if_arvalid (cpu_if_arvalid),
        .cpu_if_arready (cpu_if_arready),
        .cpu_if_rdata   (cpu_if_rdata),
        .cpu_if_rresp   (cpu_if_rresp),
        .cpu_if_rvalid  (cpu_if_rvalid),
        .cpu_if_rready  (cpu_if_rready),
        .mmcm_locked    (mmcm_locked),
        .led_out        (led_out)
    );

    always #5 clk_200 = ~clk_200;

    int unsigned cyc_cnt = 0;
    always @(posedge clk_200) cyc_cnt <= cyc_cnt + 1;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] VER = 32'h0001_0000;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        logic [1:0]  resp;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_ctl"}, {20'b0, cpu_if_awready, cpu_if_wready, cpu_if_bvalid, cpu_if_bresp,
                            cpu_if_arready, cpu_if_rvalid, cpu_if_rresp, led_out}, 32'd0);
        chk({tag, "_rdata"}, cpu_if_rdata, 32'd0);
    endtask

    // Entered and left at posedge+1. hold_b leaves bvalid pending.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input bit hold_b,
                            output logic [1:0] resp);
        int cyc;
        bit aw_done, w_done, aw_ok, w_ok;
        cyc = 0; aw_done = 0; w_done = 0;
        while (!(aw_done && w_done) && cyc < 50) begin
            cpu_if_awaddr  = a;
            cpu_if_wdata   = d;
            cpu_if_wstrb   = s;
            cpu_if_awvalid = !aw_done && (cyc >= aw_dly);
            cpu_if_wvalid  = !w_done && (cyc >= w_dly);
            aw_ok = cpu_if_awvalid && cpu_if_awready;
            w_ok  = cpu_if_wvalid && cpu_if_wready;
            @(posedge clk_200); #1;
            if (aw_ok) aw_done = 1;
            if (w_ok)  w_done  = 1;
            cyc++;
            if (!(aw_done && w_done)) begin
                chk("bvalid_early", {31'b0, cpu_if_bvalid}, 32'd0);
                if (aw_done) chk("awready_held", {31'b0, cpu_if_awready}, 32'd0);
            end
        end
        cpu_if_awvalid = 0;
        cpu_if_wvalid  = 0;
        if (!(aw_done && w_done)) chk("wr_timeout", 32'd0, 32'd1);
        chk("bvalid_rise", {31'b0, cpu_if_bvalid}, 32'd1);
        resp = cpu_if_bresp;
        if (!hold_b) begin
            cpu_if_bready = 1;
            @(posedge clk_200); #1;
            cpu_if_bready = 0;
            chk("bvalid_clr", {31'b0, cpu_if_bvalid}, 32'd0);
        end
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                           output logic [1:0] resp, output int unsigned hs_cyc);
        int cyc;
        bit ok;
        cyc = 0; ok = 0;
        cpu_if_araddr  = a;
        cpu_if_arvalid = 1;
        while (!ok && cyc < 50) begin
            ok = cpu_if_arready;
            @(posedge clk_200); #1;
            cyc++;
        end
        cpu_if_arvalid = 0;
        hs_cyc = cyc_cnt;
        if (!ok) chk("rd_timeout", 32'd0, 32'd1);
        chk("rvalid_rise", {31'b0, cpu_if_rvalid}, 32'd1);
        data = cpu_if_rdata;
        resp = cpu_if_rresp;
        cpu_if_rready = 1;
        @(posedge clk_200); #1;
        cpu_if_rready = 0;
        chk("rvalid_clr", {31'b0, cpu_if_rvalid}, 32'd0);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk_200); #1;
        end
    endtask

    logic [31:0] rd, rd2;
    logic [1:0]  rs;
    int unsigned c1, c2;
    logic [2:0]  led_s [0:23];
    int          run_len, nruns;
    bit          ok;

    initial begin
        rst_200        = 1;
        mmcm_locked    = 1;
        cpu_if_awaddr  = '0;
        cpu_if_awprot  = '0;
        cpu_if_awvalid = 0;
        cpu_if_wdata   = '0;
        cpu_if_wstrb   = '0;
        cpu_if_wvalid  = 0;
        cpu_if_bready  = 0;
        cpu_if_araddr  = '0;
        cpu_if_arprot  = '0;
        cpu_if_arvalid = 0;
        cpu_if_rready  = 0;

        // Vector table: {wr, addr, data, strb, aw_dly, w_dly, resp, read data}
        vecs.push_back('{1'b0, 32'h00, 32'h0,         4'h0, 0, 0, 2'b00, VER});
        vecs.push_back('{1'b1, 32'h04, 32'hDEADBEEF,  4'b0101, 0, 2, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 32'h04, 32'h0,         4'h0, 0, 0, 2'b00, 32'h00AD00EF});
        vecs.push_back('{1'b1, 32'h04, 32'h11223344,  4'b1010, 0, 0, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 32'h04, 32'h0,         4'h0, 0, 0, 2'b00, 32'h11AD33EF});
        vecs.push_back('{1'b1, 32'h04, 32'hCAFEF00D,  4'hF, 3, 0, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 32'h04, 32'h0,         4'h0, 0, 0, 2'b00, 32'hCAFEF00D});
        vecs.push_back('{1'b0, 32'h1000_0007, 32'h0,  4'h0, 0, 0, 2'b00, 32'hCAFEF00D});
        vecs.push_back('{1'b1, 32'h00, 32'h12345678,  4'hF, 0, 0, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 32'h00, 32'h0,         4'h0, 0, 0, 2'b00, VER});
        vecs.push_back('{1'b1, 32'h08, 32'hFFFFFFFF,  4'hF, 0, 0, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 32'h08, 32'h0,         4'h0, 0, 0, 2'b00, 32'h00000107});
        vecs.push_back('{1'b1, 32'h08, 32'h00000000,  4'b0010, 0, 0, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 32'h08, 32'h0,         4'h0, 0, 0, 2'b00, 32'h00000007});
        vecs.push_back('{1'b1, 32'h08, 32'h00000000,  4'hF, 0, 0, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 32'h08, 32'h0,         4'h0, 0, 0, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 32'h0C, 32'h0,         4'h0, 0, 0, 2'b00, 32'h05F5E100});
        vecs.push_back('{1'b1, 32'h0C, 32'hAABBCCDD,  4'b0110, 1, 0, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 32'h0C, 32'h0,         4'h0, 0, 0, 2'b00, 32'h05BBCC00});
        vecs.push_back('{1'b0, 32'h14, 32'h0,         4'h0, 0, 0, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 32'h20, 32'h0,         4'h0, 0, 0, 2'b10, 32'h0});
        vecs.push_back('{1'b0, 32'h14, 32'h0,         4'h0, 0, 0, 2'b00, 32'h2});
        vecs.push_back('{1'b1, 32'h14, 32'h00000002,  4'hF, 0, 0, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 32'h14, 32'h0,         4'h0, 0, 0, 2'b00, 32'h0});
        vecs.push_back('{1'b1, 32'h18, 32'h12345678,  4'hF, 0, 0, 2'b10, 32'h0});
        vecs.push_back('{1'b0, 32'h14, 32'h0,         4'h0, 0, 0, 2'b00, 32'h2});
        vecs.push_back('{1'b1, 32'h14, 32'h00000002,  4'hF, 0, 0, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 32'h14, 32'h0,         4'h0, 0, 0, 2'b00, 32'h0});

        // Reset state and init-flop release.
        cycles(3);
        chk_outs_zero("rst");
        rst_200 = 0;
        #1;
        chk("ready_pre_init", {29'b0, cpu_if_awready, cpu_if_wready, cpu_if_arready}, 32'd0);
        cycles(1);
        chk("ready_post_init", {29'b0, cpu_if_awready, cpu_if_wready, cpu_if_arready}, 32'd7);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb,
                         vecs[i].aw_dly, vecs[i].w_dly, 1'b0, rs);
                chk($sformatf("vec%0d_bresp", i), {30'b0, rs}, {30'b0, vecs[i].resp});
            end else begin
                do_read(vecs[i].addr, rd, rs, c1);
                chk($sformatf("vec%0d_rresp", i), {30'b0, rs}, {30'b0, vecs[i].resp});
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
            end
        end

        // Read of VERSION held with rready low for five cycles.
        cpu_if_araddr  = 32'h00;
        cpu_if_arvalid = 1;
        cycles(1);
        cpu_if_arvalid = 0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_rdata", cpu_if_rdata, VER);
            chk("hold_flags", {30'b0, cpu_if_rvalid, cpu_if_arready}, 32'd2);
            cycles(1);
        end
        cpu_if_rready = 1;
        cycles(1);
        cpu_if_rready = 0;
        chk("hold_release", {30'b0, cpu_if_rvalid, cpu_if_arready}, 32'd1);

        // UPTIME advances by one per cycle between two reads.
        do_read(32'h10, rd, rs, c1);
        cycles(7);
        do_read(32'h10, rd2, rs, c2);
        chk("uptime_delta", rd2 - rd, c2 - c1);

        // Blink with BLINK_DIV=4: 101/000 runs of exactly four cycles.
        do_write(32'h0C, 32'd4, 4'hF, 0, 0, 1'b0, rs);
        do_write(32'h08, 32'h105, 4'hF, 0, 0, 1'b0, rs);
        for (int i = 0; i < 24; i++) begin
            led_s[i] = led_out;
            chk("blink_val", {31'b0, (led_out == 3'b101) || (led_out == 3'b000)}, 32'd1);
            cycles(1);
        end
        run_len = -1000;
        nruns   = 0;
        for (int i = 1; i < 24; i++) begin
            run_len++;
            if (led_s[i] != led_s[i-1]) begin
                if (run_len > 0) begin
                    chk("blink_run4", run_len, 32'd4);
                    nruns++;
                end
                run_len = 0;
            end
        end
        chk("blink_nruns", {31'b0, nruns >= 3}, 32'd1);

        // BLINK_DIV=0 behaves like 1: toggle every cycle.
        do_write(32'h0C, 32'd0, 4'hF, 0, 0, 1'b0, rs);
        cycles(1);
        for (int i = 0; i < 8; i++) begin
            led_s[i] = led_out;
            cycles(1);
        end
        for (int i = 1; i < 8; i++)
            chk("blink_fast", {31'b0, led_s[i] != led_s[i-1]}, 32'd1);

        // Blink disabled: static led_sw.
        do_write(32'h08, 32'h005, 4'hF, 0, 0, 1'b0, rs);
        cycles(1);
        chk("led_static", {29'b0, led_out}, 32'd5);

        // Lock loss: bit 0 becomes visible on the third edge after the fall.
        mmcm_locked = 0;
        cycles(2);
        do_read(32'h14, rd, rs, c1);
        chk("lock_not_yet", rd, 32'h0);
        mmcm_locked = 1;
        do_read(32'h14, rd, rs, c1);
        chk("lock_lost", rd, 32'h1);
        do_write(32'h14, 32'h1, 4'hF, 0, 0, 1'b0, rs);
        do_read(32'h14, rd, rs, c1);
        chk("lock_clr", rd, 32'h0);
        cycles(4);

        // W1C lands on the same edge as a new lock loss: the set wins.
        mmcm_locked = 0;
        cycles(2);
        do_write(32'h14, 32'h1, 4'hF, 0, 0, 1'b0, rs);
        mmcm_locked = 1;
        do_read(32'h14, rd, rs, c1);
        chk("set_wins", rd, 32'h1);
        do_write(32'h14, 32'h1, 4'hF, 0, 0, 1'b0, rs);
        do_read(32'h14, rd, rs, c1);
        chk("set_wins_clr", rd, 32'h0);
        cycles(4);

        // Reset while an AW is held.
        do_write(32'h08, 32'h007, 4'hF, 0, 0, 1'b0, rs);
        cycles(1);
        chk("led_pre_rst", {29'b0, led_out}, 32'd7);
        cpu_if_awaddr  = 32'h04;
        cpu_if_awvalid = 1;
        cycles(1);
        cpu_if_awvalid = 0;
        chk("aw_held", {31'b0, cpu_if_awready}, 32'd0);
        rst_200 = 1;
        #1;
        chk_outs_zero("rst_aw");
        cycles(2);
        rst_200 = 0;
        #1;
        chk("rst_aw_ready_low", {29'b0, cpu_if_awready, cpu_if_wready, cpu_if_arready}, 32'd0);
        cycles(1);
        chk("rst_aw_ready_up", {29'b0, cpu_if_awready, cpu_if_wready, cpu_if_arready}, 32'd7);

        // Reset with B and R both pending.
        do_write(32'h04, 32'h55, 4'hF, 0, 0, 1'b1, rs);
        cpu_if_araddr  = 32'h04;
        cpu_if_arvalid = 1;
        cycles(1);
        cpu_if_arvalid = 0;
        chk("pend_rdata", cpu_if_rdata, 32'h55);
        chk("pend_flags", {30'b0, cpu_if_bvalid, cpu_if_rvalid}, 32'd3);
        rst_200 = 1;
        #1;
        chk_outs_zero("rst_br");
        cycles(2);
        rst_200 = 0;
        #1;
        chk("rst_br_ready_low", {29'b0, cpu_if_awready, cpu_if_wready, cpu_if_arready}, 32'd0);
        cycles(1);
        chk("rst_br_ready_up", {29'b0, cpu_if_awready, cpu_if_wready, cpu_if_arready}, 32'd7);
        chk("rst_br_no_resp", {30'b0, cpu_if_bvalid, cpu_if_rvalid}, 32'd0);
        do_read(32'h04, rd, rs, c1);
        chk("rst_scratch", rd, 32'h0);
        do_read(32'h0C, rd, rs, c1);
        chk("rst_blink_div", rd, 32'h05F5E100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_if_regs.md
Name: cpu_if_regs

Overview:
- AXI4-Lite slave register bank on the PS-to-PL cpu_if master port. Terminates the master port on the PL side.
- Gives software a version ID, a scratch register, LED control with hardware blink, an uptime counter and a sticky status register.
- Runs on the 200 MHz fabric clock. Drives the board LED outputs.

Parameters:
- ADDR_W, 32, width of cpu_if_awaddr/araddr; only bits [7:2] decoded, all other bits ignored.
- VERSION, 32'h0001_0000, value returned at offset 0x00.
- BLINK_DIV_RST, 32'd100_000_000, reset value of BLINK_DIV (0.5 s half-period at 200 MHz).

Ports:
- clk_200  input  1  fabric clock, all logic.
- rst_200  input  1  asynchronous active-high reset.
- cpu_if_awaddr  input  ADDR_W  write address.
- cpu_if_awprot  input  3  ignored.
- cpu_if_awvalid  input  1  write address valid.
- cpu_if_awready  output  1  write address ready.
- cpu_if_wdata  input  32  write data.
- cpu_if_wstrb  input  4  byte strobes.
- cpu_if_wvalid  input  1  write data valid.
- cpu_if_wready  output  1  write data ready.
- cpu_if_bresp  output  2  write response.
- cpu_if_bvalid  output  1  write response valid.
- cpu_if_bready  input  1  write response ready.
- cpu_if_araddr  input  ADDR_W  read address.
- cpu_if_arprot  input  3  ignored.
- cpu_if_arvalid  input  1  read address valid.
- cpu_if_arready  output  1  read address ready.
- cpu_if_rdata  output  32  read data.
- cpu_if_rresp  output  2  read response.
- cpu_if_rvalid  output  1  read data valid.
- cpu_if_rready  input  1  read data ready.
- mmcm_locked  input  1  asynchronous lock flag; 2-flop synchronised internally.
- led_out  output  3  LED drive.

Behaviour:
- Reset: all outputs 0. Ready outputs are held 0 by an init flop that sets on the first clk_200 edge after rst_200 falls. Registers reset as follows:
  - SCRATCH = 0
  - LED_CTRL = 0
  - BLINK_DIV = BLINK_DIV_RST
  - UPTIME = 0
  - STATUS = 0
  - blink counter = 0
  - blink phase = 0
- Write channel:
  - awready = init & ~aw_held & ~bvalid.
  - wready = init & ~w_held & ~bvalid.
  - AW and W are captured independently, in either order or in the same cycle.
  - Once both are held (or handshake together), the register update occurs on that edge and bvalid rises the next cycle. Held flags clear at the same time.
  - bvalid stays high until bready. A new AW/W is not accepted while bvalid is high.
- Read channel:
  - arready = init & ~rvalid.
  - On AR handshake at edge N, rdata/rresp are registered and rvalid is high from N+1 until rready.
  - rdata is stable while rvalid is high.
- Response codes: mapped offset gives OKAY (2'b00). Unmapped offset (>0x14) gives SLVERR (2'b10) with rdata = 0; writes to unmapped offsets have no register effect.
- Register map (byte offsets):
  - 0x00 VERSION (RO): writes are ignored and return OKAY.
  - 0x04 SCRATCH (RW): 32-bit, per-byte wstrb.
  - 0x08 LED_CTRL (RW): [2:0] led_sw, [8] blink_en, other bits read 0. Byte strobes apply.
  - 0x0C BLINK_DIV (RW): 32-bit, per-byte wstrb.
  - 0x10 UPTIME (RO): free-running, +1 per cycle, wraps 0xFFFF_FFFF to 0.
  - 0x14 STATUS (W1C):
    - [0] lock_lost: set on a synchronised mmcm_locked 1->0 edge.
    - [1] bus_err: set on any SLVERR response.
    - Set and clear in the same cycle: set wins.
- Blink logic:
  - When blink_en = 1, the counter increments each cycle. At count >= max(BLINK_DIV,1)-1 it resets to 0 and the phase toggles.
  - When blink_en = 0, counter = 0 and phase = 0.
  - Writing BLINK_DIV while the counter is already >= the new value gives a toggle on the next cycle.
- led_out is registered: led_sw when blink_en = 0, led_sw & {3{phase}} when blink_en = 1.
- Reset mid-transaction: any held AW/W and any pending B/R are discarded, and outputs return to reset values immediately.

Test Plan:
- Write SCRATCH 0xDEADBEEF with wstrb=4'b0101, AW two cycles before W -> bvalid one cycle after W handshake, bresp=00; read 0x04 returns 0x00AD00EF.
- Read 0x00 with rready held low 5 cycles -> rvalid high from the cycle after arready, rdata=0x00010000 stable throughout, arready low until rready.
- Read 0x20 -> rresp=10, rdata=0; subsequent read of STATUS returns 0x2; write 0x2 to STATUS then read returns 0x0.
- LED_CTRL=0x105, BLINK_DIV=4 -> led_out alternates 3'b101 and 3'b000 every 4 cycles; BLINK_DIV=0 -> toggles every cycle.
- Drop mmcm_locked for 3 cycles -> STATUS[0]=1 three cycles after the fall; W1C write coinciding with a second fall leaves bit 0 set.
- Assert rst_200 while AW is held and bvalid is pending -> all outputs 0 immediately; after release, readies rise one cycle later and SCRATCH reads 0.
